dds_multi: RTL and testbench

Parametrised multi-channel DDS waveform generator. Software programs it through the same single-cycle register write bus (`m_wr`/`m_addr`/`m_wrdata`) that the uart_scope command decoder drives. Each of `CH` channels has its own 32-bit frequency word, phase word, waveform mode and duty setting. A shared programmable sample tick (`dds_flag`) paces the scope sampler and, when compiled in, steps a per-channel linear frequency sweep.

---
 rtl/dds_multi.sv | 181 ++++++++++++++++++
 tb/tb_dds_multi.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_multi.sv
// dds_multi: multi-channel DDS waveform generator with a register-write
// programming bus and a shared programmable sample tick (dds_flag).
// Optional feature: define DDS_SWEEP_EN to add a per-channel linear
// frequency sweep. The sweep advances on each dds_flag pulse.
module dds_multi #(
  parameter int unsigned CH        = 2,
  parameter int unsigned OUT_W     = 10,
  parameter int unsigned PW_W      = 12,
  parameter logic [31:0] FWORD_RST = 32'h035B_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_wr,
  input  logic [7:0]            m_addr,
  input  logic [15:0]           m_wrdata,
  output logic [CH*OUT_W-1:0]   dds_data,
  output logic                  dds_flag
);

  localparam logic [31:0] S_CNT_MAX_RST = 32'd49999;

  logic        sample_en;
  logic [31:0] s_cnt_max;
  logic [31:0] s_cnt;
  logic        glb_wr;
  logic        sync_wr;

  assign glb_wr  = m_wr && (m_addr[7:4] == 4'hF);
  assign sync_wr = glb_wr && (m_addr[3:0] == 4'h3);

  // Global register file: sample enable and sample period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_en <= 1'b0;
      s_cnt_max <= S_CNT_MAX_RST;
    end else if (glb_wr) begin
      case (m_addr[3:0])
        4'h0:    sample_en         <= m_wrdata[0];
        4'h1:    s_cnt_max[15:0]   <= m_wrdata;
        4'h2:    s_cnt_max[31:16]  <= m_wrdata;
        default: ;
      endcase
    end
  end

  // Sample counter; dds_flag is registered one cycle after cnt reaches MAX.
  // The >= wrap keeps the counter bounded if MAX is lowered below cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt    <= '0;
      dds_flag <= 1'b0;
    end else if (!sample_en) begin
      s_cnt    <= '0;
      dds_flag <= 1'b0;
    end else begin
      dds_flag <= (s_cnt == s_cnt_max);
      s_cnt    <= (s_cnt >= s_cnt_max) ? '0 : s_cnt + 32'd1;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic                ch_wr;
    logic                en;
    logic [31:0]         fword;
    logic [31:0]         acc;
    logic [PW_W-1:0]     pword;
    logic [1:0]          wave;
    logic [7:0]          duty;
    logic [PW_W-1:0]     p;
    logic [OUT_W-1:0]    q;
    logic [OUT_W-1:0]    sample;
    logic [OUT_W-1:0]    out_q;
`ifdef DDS_SWEEP_EN
    logic                sweep_on;
    logic [31:0]         step;
    logic [31:0]         fend;
    logic [31:0]         start;
    logic [31:0]         sweep_sum;

    assign sweep_sum = fword + step;
`endif

    assign ch_wr = m_wr && (m_addr[7:4] == 4'(k));

    // Per-channel control registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        en    <= 1'b0;
        pword <= '0;
        wave  <= '0;
        duty  <= '0;
`ifdef DDS_SWEEP_EN
        sweep_on <= 1'b0;
        step     <= '0;
        fend     <= '0;
`endif
      end else if (ch_wr) begin
        case (m_addr[3:0])
          4'd0: en    <= m_wrdata[0];
          4'd3: pword <= PW_W'(m_wrdata);
          4'd4: begin
            wave <= m_wrdata[1:0];
`ifdef DDS_SWEEP_EN
            sweep_on <= m_wrdata[2];
`endif
          end
          4'd5: duty  <= m_wrdata[7:0];
`ifdef DDS_SWEEP_EN
          4'd6: step[15:0]  <= m_wrdata;
          4'd7: step[31:16] <= m_wrdata;
          4'd8: fend[15:0]  <= m_wrdata;
          4'd9: fend[31:16] <= m_wrdata;
`endif
          default: ;
        endcase
      end
    end

    // Frequency word: bus writes take priority over a sweep step
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fword <= FWORD_RST;
`ifdef DDS_SWEEP_EN
        start <= '0;
`endif
      end else if (ch_wr && (m_addr[3:0] == 4'd1)) begin
        fword[15:0] <= m_wrdata;
`ifdef DDS_SWEEP_EN
        start[15:0] <= m_wrdata;
`endif
      end else if (ch_wr && (m_addr[3:0] == 4'd2)) begin
        fword[31:16] <= m_wrdata;
`ifdef DDS_SWEEP_EN
        start[31:16] <= m_wrdata;
`endif
      end
`ifdef DDS_SWEEP_EN
      else if (dds_flag && en && sweep_on && (step != '0)) begin
        fword <= (sweep_sum >= fend) ? start : sweep_sum;
      end
`endif
    end

    // Phase accumulator: SYNC and disable both force zero
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc <= '0;
      end else if (sync_wr || !en) begin
        acc <= '0;
      end else begin
        acc <= acc + fword;
      end
    end

    // Waveform shaping from the offset phase
    always_comb begin
      p      = acc[31 -: PW_W] + pword;
      q      = p[PW_W-2 -: OUT_W];
      sample = '0;
      case (wave)
        2'd0:    sample = p[PW_W-1 -: OUT_W];
        2'd1:    sample = p[PW_W-1] ? ~q : q;
        2'd2:    sample = (p[PW_W-1 -: 8] < duty) ? '1 : '0;
        default: sample = {1'b1, {(OUT_W-1){1'b0}}};
      endcase
      if (!en) sample = '0;
    end

    // Output register stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q <= '0;
      end else begin
        out_q <= sample;
      end
    end

    assign dds_data[k*OUT_W +: OUT_W] = out_q;
  end

endmodule

// File: tb/tb_dds_multi.sv
// Directed self-checking bench for dds_multi (CH=2, OUT_W=10, PW_W=12).
module tb_dds_multi;

  localparam int unsigned CH    = 2;
  localparam int unsigned OUT_W = 10;
  localparam int unsigned PW_W  = 12;

  logic                clk;
  logic                rst;
  logic                m_wr;
  logic [7:0]          m_addr;
  logic [15:0]         m_wrdata;
  logic [CH*OUT_W-1:0] dds_data;
  logic                dds_flag;

  int errors;
  int checks;

  dds_multi #(
    .CH(CH),
    .OUT_W(OUT_W),
    .PW_W(PW_W),
    .FWORD_RST(32'h035B_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m_wr(m_wr),
    .m_addr(m_addr),
    .m_wrdata(m_wrdata),
    .dds_data(dds_data),
    .dds_flag(dds_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    m_wr     = 1'b1;
    m_addr   = a;
    m_wrdata = d;
    @(negedge clk);
    m_wr     = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] accm;
    logic [9:0]  e0;
    #1;
    checks++;
    if (dds_data !== '0 || dds_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: data=%h flag=%b required data=0 flag=0", dds_data, dds_flag);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr(8'h00, 16'h0001);
    accm = '0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      e0 = accm[31:22];
      checks++;
      if (dds_data[9:0] !== e0) begin
        errors++;
        $display("FAIL default_fword j=%0d: ch0=%0d required %0d", j, dds_data[9:0], e0);
      end
      accm = accm + 32'h035B_0000;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dds_data !== '0 || dds_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: data=%h flag=%b required data=0 flag=0", dds_data, dds_flag);
    end
    @(negedge clk);
    checks++;
    if (dds_data !== '0) begin
      errors++;
      $display("FAIL reset_hold: data=%h required 0", dds_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_saw;
    logic [9:0] e0;
    wr(8'h01, 16'h0000);
    wr(8'h02, 16'h0010);
    wr(8'h00, 16'h0001);
    wr(8'hF3, 16'h0000);
    for (int j = 1; j <= 4100; j++) begin
      @(negedge clk);
      if (j <= 12 || j >= 4094) begin
        e0 = 10'((j - 1) >> 2);
        checks++;
        if (dds_data[9:0] !== e0) begin
          errors++;
          $display("FAIL saw_ch0 j=%0d: got %0d required %0d", j, dds_data[9:0], e0);
        end
        checks++;
        if (dds_data[19:10] !== 10'd0) begin
          errors++;
          $display("FAIL saw_ch1_disabled j=%0d: got %0d required 0", j, dds_data[19:10]);
        end
      end
    end
  endtask

  task automatic test_phase_sync;
    logic [9:0]  e0;
    logic [9:0]  e1;
    logic [11:0] p;
    logic [11:0] p1;
    logic [9:0]  q;
    wr(8'h11, 16'h0000);
    wr(8'h12, 16'h0010);
    wr(8'h13, 16'd1024);
    wr(8'h10, 16'h0001);
    wr(8'hF3, 16'h0000);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      e0 = 10'((j - 1) >> 2);
      e1 = e0 + 10'd256;
      checks++;
      if (dds_data[9:0] !== e0 || dds_data[19:10] !== e1) begin
        errors++;
        $display("FAIL phase_lead j=%0d: ch0=%0d ch1=%0d required ch0=%0d ch1=%0d",
                 j, dds_data[9:0], dds_data[19:10], e0, e1);
      end
    end
    // ch0 triangle, ch1 square with 50% duty
    wr(8'h04, 16'h0001);
    wr(8'h15, 16'd128);
    wr(8'h14, 16'h0002);
    wr(8'hF3, 16'h0000);
    for (int j = 1; j <= 4100; j++) begin
      @(negedge clk);
      if (j inside {1, 2, 3, 1024, 1025, 2048, 2049, 2050, 3072, 3073, 4096, 4097}) begin
        p  = 12'(j - 1);
        q  = p[10:1];
        e0 = p[11] ? ~q : q;
        p1 = p + 12'd1024;
        e1 = (p1 < 12'd2048) ? 10'h3FF : 10'h000;
        checks++;
        if (dds_data[9:0] !== e0) begin
          errors++;
          $display("FAIL triangle j=%0d: got %0d required %0d", j, dds_data[9:0], e0);
        end
        checks++;
        if (dds_data[19:10] !== e1) begin
          errors++;
          $display("FAIL square j=%0d: got %0d required %0d", j, dds_data[19:10], e1);
        end
      end
    end
    wr(8'h04, 16'h0003);
    wr(8'h15, 16'h0000);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checks++;
      if (dds_data[9:0] !== 10'd512) begin
        errors++;
        $display("FAIL midscale j=%0d: got %0d required 512", j, dds_data[9:0]);
      end
      checks++;
      if (dds_data[19:10] !== 10'd0) begin
        errors++;
        $display("FAIL duty_zero j=%0d: got %0d required 0", j, dds_data[19:10]);
      end
    end
  endtask

  task automatic test_addr_decode;
    logic [9:0] e0;
    logic [9:0] e1;
    wr(8'h04, 16'h0000);
    wr(8'h14, 16'h0000);
    wr(8'h25, 16'h0003);
    wr(8'h0A, 16'hFFFF);
    wr(8'h1A, 16'hFFFF);
    wr(8'h1F, 16'hFFFF);
    wr(8'hF3, 16'h0000);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      e0 = 10'((j - 1) >> 2);
      e1 = e0 + 10'd256;
      checks++;
      if (dds_data[9:0] !== e0 || dds_data[19:10] !== e1) begin
        errors++;
        $display("FAIL addr_decode j=%0d: ch0=%0d ch1=%0d required ch0=%0d ch1=%0d",
                 j, dds_data[9:0], dds_data[19:10], e0, e1);
      end
    end
  endtask

  task automatic test_sample_tick;
    logic ef;
    wr(8'hF1, 16'd9);
    wr(8'hF2, 16'd0);
    wr(8'hF0, 16'h0001);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      ef = (k >= 10) && (((k - 10) % 10) == 0);
      checks++;
      if (dds_flag !== ef) begin
        errors++;
        $display("FAIL tick_max9 k=%0d: flag=%b required %b", k, dds_flag, ef);
      end
    end
    wr(8'hF0, 16'h0000);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      checks++;
      if (dds_flag !== 1'b0) begin
        errors++;
        $display("FAIL tick_disabled k=%0d: flag=%b required 0", k, dds_flag);
      end
    end
    wr(8'hF1, 16'd0);
    wr(8'hF0, 16'h0001);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (dds_flag !== 1'b1) begin
        errors++;
        $display("FAIL tick_max0 k=%0d: flag=%b required 1", k, dds_flag);
      end
    end
    wr(8'hF0, 16'h0000);
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (dds_flag !== 1'b0) begin
        errors++;
        $display("FAIL tick_max0_off k=%0d: flag=%b required 0", k, dds_flag);
      end
    end
  endtask

`ifdef DDS_SWEEP_EN
  task automatic test_sweep;
    logic [31:0] exp_seq [4];
    int n;
    exp_seq[0] = 32'h200;
    exp_seq[1] = 32'h300;
    exp_seq[2] = 32'h100;
    exp_seq[3] = 32'h200;
    wr(8'h01, 16'h0100);
    wr(8'h02, 16'h0000);
    wr(8'h06, 16'h0100);
    wr(8'h07, 16'h0000);
    wr(8'h08, 16'h0400);
    wr(8'h09, 16'h0000);
    wr(8'h04, 16'h0004);
    wr(8'h00, 16'h0001);
    wr(8'hF1, 16'd3);
    wr(8'hF2, 16'd0);
    wr(8'hF0, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (dds_flag !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) begin
        checks++;
        errors++;
        $display("FAIL sweep_wait i=%0d: no tick within 20 cycles", i);
      end
      @(negedge clk);
      checks++;
      if (dut.g_ch[0].fword !== exp_seq[i]) begin
        errors++;
        $display("FAIL sweep_step i=%0d: fword=%h required %h", i, dut.g_ch[0].fword, exp_seq[i]);
      end
    end
    n = 0;
    while (dds_flag !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    m_wr     = 1'b1;
    m_addr   = 8'h01;
    m_wrdata = 16'h0180;
    @(negedge clk);
    m_wr = 1'b0;
    checks++;
    if (dut.g_ch[0].fword !== 32'h0000_0180) begin
      errors++;
      $display("FAIL sweep_write_wins: fword=%h required 00000180", dut.g_ch[0].fword);
    end
    wr(8'hF0, 16'h0000);
  endtask
`endif

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    m_wr     = 1'b0;
    m_addr   = '0;
    m_wrdata = '0;
    test_reset;
    test_saw;
    test_phase_sync;
    test_addr_decode;
    test_sample_tick;
`ifdef DDS_SWEEP_EN
    test_sweep;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
